// File: rtl/store_buffer_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_buffer_dmem                                            |
// | Description : Single-port data memory fronted by a circular store buffer   |
// |               with youngest-match load forwarding and load-priority drain. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module store_buffer_dmem #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Empty,
    output logic [4:0]  Count
);

    localparam int         c_AW    = $clog2(MEM_WORDS);
    localparam int         c_PW    = $clog2(DEPTH);
    localparam logic [4:0] c_DEPTH = 5'(DEPTH);

    logic [31:0]     r_mem  [MEM_WORDS];
    logic [c_AW-1:0] r_idx  [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [4:0]      r_count;

    logic [c_AW-1:0] w_idx;
    logic            w_drain;
    logic            w_push;
    logic            w_hit;
    logic [31:0]     w_fwd_data;
    logic            w_unused;

    assign w_idx    = A[c_AW+1:2];
    assign w_unused = ^{A[31:c_AW+2], A[1:0]};

    // Loads own the single array port, so a load cycle blocks the drain.
    assign w_drain = (r_count != 5'd0) && !MemRead;
    assign w_push  = MemWrite && ((r_count != c_DEPTH) || w_drain);

    assign Stall = MemWrite && (r_count == c_DEPTH) && !w_drain;
    assign Empty = (r_count == 5'd0);
    assign Count = r_count;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((5'(i) < r_count) && (r_idx[r_head + c_PW'(i)] == w_idx)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[r_head + c_PW'(i)];
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            ReadData = w_hit ? w_fwd_data : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + c_PW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_push && !w_drain) begin
                r_count <= r_count + 5'd1;
            end else if (w_drain && !w_push) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

    // Entry payloads carry no reset; validity is defined by head/count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx[r_tail]  <= w_idx;
            r_data[r_tail] <= WD;
        end
    end

    // Count is forced to zero during reset, which also suppresses any drain write.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_mem[r_idx[r_head]] <= r_data[r_head];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_buffer_dmem                                         |
// | Description : Queue-based reference model bench for store_buffer_dmem.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_store_buffer_dmem;

    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] WD;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic [4:0]  Count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending stores oldest-first, plus a plain word array.
    logic [41:0] q [$];
    logic [31:0] mem_m [MEM_WORDS];

    logic [31:0] rd_s;
    logic        st_s;

    store_buffer_dmem #(
        .DEPTH     (DEPTH),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .WD       (WD),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .Stall    (Stall),
        .Empty    (Empty),
        .Count    (Count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare every output to the model, then advance
    // the model by the same rules the edge applies (drain before push).
    task automatic step(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd_o, output logic st_o);
        int          cnt;
        bit          drain;
        bit          push;
        logic [9:0]  idx;
        logic [31:0] exp_rd;
        MemWrite = we;
        MemRead  = re;
        A        = a;
        WD       = wd;
        #1;
        idx    = a[11:2];
        cnt    = q.size();
        drain  = (cnt > 0) && !re;
        push   = we && ((cnt < DEPTH) || drain);
        exp_rd = 32'h0;
        if (re) begin
            exp_rd = mem_m[idx];
            for (int k = 0; k < q.size(); k++) begin
                if (q[k][41:32] == idx) exp_rd = q[k][31:0];
            end
        end
        check("ReadData", ReadData, exp_rd);
        check("Stall", 32'(Stall), 32'(we && (cnt == DEPTH) && !drain));
        check("Count", 32'(Count), 32'(cnt));
        check("Empty", 32'(Empty), 32'(cnt == 0));
        rd_o = ReadData;
        st_o = Stall;
        @(posedge clk);
        if (drain) begin
            mem_m[q[0][41:32]] = q[0][31:0];
            void'(q.pop_front());
        end
        if (push) q.push_back({idx, wd});
        #1;
    endtask

    initial begin
        int rp;
        logic [31:0] a;
        rst      = 1'b0;
        MemWrite = 1'b1;
        MemRead  = 1'b0;
        A        = '0;
        WD       = '0;
        #3;
        check("reset_Count", 32'(Count), 32'd0);
        check("reset_Empty", 32'(Empty), 32'd1);
        check("reset_Stall", 32'(Stall), 32'd0);
        #5;
        rst = 1'b1;

        // Give the first 32 words known contents; first store lands right after reset.
        for (int w = 0; w < 32; w++) step(1'b1, 1'b0, 32'(w) << 2, $urandom, rd_s, st_s);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);

        // Forwarding then drain of a single store.
        step(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd_s, st_s);
        step(1'b0, 1'b1, 32'h10, 32'h0, rd_s, st_s);
        check("fwd_deadbeef", rd_s, 32'hDEAD_BEEF);
        check("count_after_load", 32'(Count), 32'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        check("count_after_idle", 32'(Count), 32'd0);
        step(1'b0, 1'b1, 32'h10, 32'h0, rd_s, st_s);
        check("array_word4", rd_s, 32'hDEAD_BEEF);

        // Two stores to one index: youngest wins, array ends at last value.
        step(1'b1, 1'b0, 32'h20, 32'h11, rd_s, st_s);
        step(1'b1, 1'b0, 32'h20, 32'h22, rd_s, st_s);
        step(1'b0, 1'b1, 32'h20, 32'h0, rd_s, st_s);
        check("fwd_youngest", rd_s, 32'h22);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        step(1'b0, 1'b1, 32'h20, 32'h0, rd_s, st_s);
        check("array_word8", rd_s, 32'h22);

        // Loads held every cycle: buffer fills and the fifth store stalls.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 32'h44 + 32'(k) * 4, 32'hA0 + 32'(k), rd_s, st_s);
        check("full_stall", 32'(st_s), 32'd1);
        check("full_count", 32'(Count), 32'd4);
        step(1'b1, 1'b0, 32'h54, 32'hA5, rd_s, st_s);
        check("drain_push_stall", 32'(st_s), 32'd0);
        check("drain_push_count", 32'(Count), 32'd4);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);

        // Store/idle pairs walk the pointers around the ring several times.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 32'(k) * 4, 32'h100 + 32'(k), rd_s, st_s);
            check("wrap_count1", 32'(Count), 32'd1);
            step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 32'(k) * 4, 32'h0, rd_s, st_s);
            check("wrap_word", rd_s, 32'h100 + 32'(k));
        end

        // Array read with no buffered match; ReadData zero when not loading.
        step(1'b1, 1'b0, 32'h40, 32'h1234, rd_s, st_s);
        step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        step(1'b0, 1'b1, 32'h40, 32'h0, rd_s, st_s);
        check("array_word16", rd_s, 32'h1234);
        step(1'b0, 1'b0, 32'h40, 32'h0, rd_s, st_s);
        check("rd_zero_idle", rd_s, 32'h0);

        // Reset between edges discards buffered stores, array keeps old words.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h60 + 32'(k) * 4, 32'hBB00 + 32'(k), rd_s, st_s);
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midreset_Count", 32'(Count), 32'd0);
        check("midreset_Empty", 32'(Empty), 32'd1);
        check("midreset_Stall", 32'(Stall), 32'd0);
        q.delete();
        #3;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h60 + 32'(k) * 4, 32'h0, rd_s, st_s);

        // Randomized traffic with varying load pressure and junk upper/lower address bits.
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) rp = $urandom_range(10, 90);
            a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
            step(1'($urandom % 2), 1'($urandom_range(0, 99) < rp), a, $urandom, rd_s, st_s);
        end

        for (int k = 0; k <= DEPTH; k++) step(1'b0, 1'b0, 32'h0, 32'h0, rd_s, st_s);
        for (int w = 0; w < 32; w++) step(1'b0, 1'b1, 32'(w) << 2, 32'h0, rd_s, st_s);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
